simeck_crypt_core: RTL

SIMECK_CRYPT_CORE -- requirements
Module: simeck_crypt_core

---
 rtl/simeck_pkg.sv | 21 ++
 rtl/simeck_round.sv | 33 +++
 rtl/simeck_crypt_core.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/simeck_pkg.sv
// Shared Simeck definitions: controller states, mode encoding and the
// round-constant helper used by the key schedule.
package simeck_pkg;

  typedef enum logic [2:0] {
    ST_NOKEY,
    ST_EXPAND,
    ST_READY,
    ST_RUN,
    ST_HOLD
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // C = 2^w - 4: all ones except the two LSBs.
  function automatic logic [63:0] simeck_c(input int w);
    return (64'd1 << w) - 64'd4;
  endfunction

endpackage

// File: rtl/simeck_round.sv
// One combinational Simeck round, forward or inverse.
// Ports: mode_i (0 enc / 1 dec), l_i/r_i/k_i in, l_o/r_o out.
module simeck_round
  import simeck_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic            mode_i,
  input  logic [WORD-1:0] l_i,
  input  logic [WORD-1:0] r_i,
  input  logic [WORD-1:0] k_i,
  output logic [WORD-1:0] l_o,
  output logic [WORD-1:0] r_o
);

  function automatic logic [WORD-1:0] f(input logic [WORD-1:0] x);
    logic [WORD-1:0] x5;
    logic [WORD-1:0] x1;
    x5 = {x[WORD-6:0], x[WORD-1:WORD-5]};
    x1 = {x[WORD-2:0], x[WORD-1]};
    return (x & x5) ^ x1;
  endfunction

  always_comb begin
    l_o = r_i ^ f(l_i) ^ k_i;
    r_o = l_i;
    if (mode_i == MODE_DEC) begin
      l_o = r_i;
      r_o = l_i ^ f(r_i) ^ k_i;
    end
  end

endmodule

// File: rtl/simeck_crypt_core.sv
// Iterative Simeck block cipher with on-chip round-key table.
// Ports: key/in/out valid-ready handshakes, mode, data_in/data_out, key_loaded.
module simeck_crypt_core
  import simeck_pkg::*;
#(
  parameter int WORD   = 16,
  parameter int ROUNDS = 32,
  parameter int LFSR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [4*WORD-1:0] key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [2*WORD-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*WORD-1:0] data_out,
  output logic              key_loaded
);

  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);
  localparam int TAP = (LFSR_W == 6) ? 1 : 2;
  localparam logic [WORD-1:0] KC = WORD'(simeck_c(WORD));

  state_e state_q, state_d;

  logic [CW-1:0]     cnt_q;
  logic [WORD-1:0]   t0_q, t1_q, t2_q, t3_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [WORD-1:0]   l_q, r_q;
  logic              mode_q;
  logic [WORD-1:0]   rk_q;
  logic              rk_v_q;
  logic              fin_q;
  logic [WORD-1:0]   tbl_q [ROUNDS];

  logic            key_hs, in_hs;
  logic [CW-1:0]   rk_idx;
  logic [WORD-1:0] ks_k, ks_new, ks_unused;
  logic [WORD-1:0] rnd_l, rnd_r;

  assign key_hs = key_valid & key_ready;
  assign in_hs  = in_valid & in_ready;
  assign rk_idx = (mode_q == MODE_DEC) ? LAST - cnt_q : cnt_q;
  assign ks_k   = KC ^ {{(WORD-1){1'b0}}, lfsr_q[0]};
  assign data_out = {l_q, r_q};

  simeck_round #(.WORD(WORD)) u_ks (
    .mode_i (MODE_ENC),
    .l_i    (t1_q),
    .r_i    (t0_q),
    .k_i    (ks_k),
    .l_o    (ks_new),
    .r_o    (ks_unused)
  );

  simeck_round #(.WORD(WORD)) u_dp (
    .mode_i (mode_q),
    .l_i    (l_q),
    .r_i    (r_q),
    .k_i    (rk_q),
    .l_o    (rnd_l),
    .r_o    (rnd_r)
  );

  always_comb begin
    state_d    = state_q;
    key_ready  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    key_loaded = 1'b0;
    unique case (state_q)
      ST_NOKEY: begin
        key_ready = 1'b1;
        if (key_valid) state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        if (cnt_q == LAST) state_d = ST_READY;
      end
      ST_READY: begin
        key_ready  = 1'b1;
        key_loaded = 1'b1;
        // A pending key always pre-empts a pending block.
        in_ready   = ~key_valid;
        if (key_valid)     state_d = ST_EXPAND;
        else if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        key_loaded = 1'b1;
        if (fin_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        key_loaded = 1'b1;
        out_valid  = 1'b1;
        if (out_ready) state_d = ST_READY;
      end
      default: state_d = ST_NOKEY;
    endcase
  end

  // Table is written without reset; contents only matter after expansion.
  always_ff @(posedge clk) begin
    if (state_q == ST_EXPAND) tbl_q[cnt_q] <= t0_q;
  end

  // The round key is fetched one cycle ahead of its use (registered table
  // read), so RUN spans ROUNDS+1 cycles: one fetch, then ROUNDS rounds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_NOKEY;
      cnt_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      t3_q    <= '0;
      lfsr_q  <= '1;
      l_q     <= '0;
      r_q     <= '0;
      mode_q  <= MODE_ENC;
      rk_q    <= '0;
      rk_v_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_v_q  <= (state_q == ST_RUN);

      if (key_hs || in_hs) begin
        cnt_q <= '0;
      end else if (cnt_q != LAST &&
                   (state_q == ST_EXPAND ||
                    (state_q == ST_RUN && !fin_q))) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (key_hs) begin
        t0_q   <= key_in[WORD-1:0];
        t1_q   <= key_in[2*WORD-1:WORD];
        t2_q   <= key_in[3*WORD-1:2*WORD];
        t3_q   <= key_in[4*WORD-1:3*WORD];
        lfsr_q <= '1;
      end else if (state_q == ST_EXPAND) begin
        t0_q   <= t1_q;
        t1_q   <= t2_q;
        t2_q   <= t3_q;
        t3_q   <= ks_new;
        lfsr_q <= {lfsr_q[0] ^ lfsr_q[TAP], lfsr_q[LFSR_W-1:1]};
      end

      if (in_hs) begin
        l_q    <= data_in[2*WORD-1:WORD];
        r_q    <= data_in[WORD-1:0];
        mode_q <= mode;
        fin_q  <= 1'b0;
      end else if (state_q == ST_RUN) begin
        if (!fin_q) begin
          rk_q  <= tbl_q[rk_idx];
          fin_q <= (cnt_q == LAST);
        end
        if (rk_v_q) begin
          l_q <= rnd_l;
          r_q <= rnd_r;
        end
      end
    end
  end

endmodule
